// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial transmitter: FSM state encoding
// and the parity-mode constants used to parametrise the frame format.
package serial_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/serial_tx_fifo.sv
// Small first-word-fall-through FIFO that queues payload words ahead of the
// serialiser. A write while full is dropped; fullness is judged on the
// registered occupancy, so a same-cycle pop cannot make room for a write.
module serial_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_acc;
    logic             rd_acc;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rd_ptr_q];
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
    end

    // Storage array; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/serial_tx_frame.sv
// Framed serial transmitter: start bit, DATA_BITS payload bits LSB first,
// optional parity, one or two stop bits. A small FIFO lets producers queue
// words while a frame is on the line; frames run back to back when queued.
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          tx,
    input  logic                          block,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          new_data,
    output logic                          full,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    if (CLK_PER_BIT < 2) begin : g_bad_cpb
        $error("serial_tx_frame: CLK_PER_BIT must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("serial_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("serial_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("serial_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("serial_tx_frame: FIFO_DEPTH must be a power of two, 2 or more");
    end

    state_e                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d, baud_next;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  line_busy_q;
    logic                  block_q;
    logic                  overflow_q;

    logic                  baud_last;
    logic                  bit_last;
    logic                  stop_last;
    logic                  can_start;
    logic                  pop;
    logic                  par_calc;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic                  fifo_empty;

    serial_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (new_data),
        .din   (data),
        .rd_en (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_W'(CLK_PER_BIT - 1));
    assign baud_next = baud_last ? '0 : baud_q + 1'b1;
    assign bit_last  = (bit_q == BIT_W'(DATA_BITS - 1));
    assign stop_last = (stop_q == 1'(STOP_BITS - 1));
    assign can_start = !fifo_empty && !block_q;
    assign par_calc  = (PARITY == PAR_ODD) ? ~(^fifo_dout) : (^fifo_dout);

    // Frame sequencing; a pop loads the head word and its parity together.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = par_calc;
                    state_d = S_START;
                end
            end
            S_START: begin
                baud_d = baud_next;
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_next;
                if (baud_last) begin
                    if (bit_last) begin
                        stop_d = 1'b0;
                        if (PARITY != PAR_NONE) state_d = S_PARITY;
                        else                    state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_next;
                if (baud_last) begin
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                baud_d = baud_next;
                if (baud_last) begin
                    if (!stop_last) begin
                        stop_d = stop_q + 1'b1;
                    end else if (can_start) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        par_d   = par_calc;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the current state; registered below so tx never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[bit_q];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, counters, registered line output, block sync and overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            line_busy_q <= 1'b0;
            block_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            line_busy_q <= (state_q != S_IDLE);
            block_q     <= block;
            overflow_q  <= new_data && full;
        end
    end

    // line_busy_q covers the last stop cycle that tx still shows after the FSM idles.
    assign busy     = (state_q != S_IDLE) || line_busy_q || !fifo_empty || block_q;
    assign tx       = tx_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: four instances with different frame formats,
// a line monitor per instance decoding frames against a queue of accepted
// words, plus directed latency, FIFO, block and reset scenarios.
module tb_serial_tx_frame;

    localparam int NI    = 4;
    localparam int DEPTH = 4;
    localparam int CPB_A  [NI] = '{4, 4, 4, 3};
    localparam int DB_A   [NI] = '{8, 8, 8, 5};
    localparam int PAR_A  [NI] = '{0, 2, 1, 0};
    localparam int STOP_A [NI] = '{1, 2, 1, 1};

    logic       clk = 1'b0;
    logic       rst_w      [NI];
    logic       block_w    [NI];
    logic       new_data_w [NI];
    logic [8:0] data_w     [NI];
    logic       tx_w       [NI];
    logic       full_w     [NI];
    logic       busy_w     [NI];
    logic       ovf_w      [NI];
    logic [2:0] cnt_w      [NI];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [8:0] exp_mem [NI][64];
    int exp_wr [NI];
    int exp_rd [NI];
    int exp_start [NI];
    int frames [NI];
    int start_log [NI][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        serial_tx_frame #(
            .CLK_PER_BIT (CPB_A[gi]),
            .DATA_BITS   (DB_A[gi]),
            .PARITY      (PAR_A[gi]),
            .STOP_BITS   (STOP_A[gi]),
            .FIFO_DEPTH  (DEPTH)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_w[gi]),
            .tx         (tx_w[gi]),
            .block      (block_w[gi]),
            .data       (data_w[gi][DB_A[gi]-1:0]),
            .new_data   (new_data_w[gi]),
            .full       (full_w[gi]),
            .busy       (busy_w[gi]),
            .overflow   (ovf_w[gi]),
            .fifo_count (cnt_w[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int periods(input int idx);
        return 1 + DB_A[idx] + ((PAR_A[idx] != 0) ? 1 : 0) + STOP_A[idx];
    endfunction

    // Expected line level per bit period, bit 0 = start bit.
    function automatic logic [31:0] frame_vec(input int idx, input logic [8:0] b);
        logic [31:0] v;
        int ones;
        int pos;
        v = '0;
        ones = 0;
        for (int i = 0; i < DB_A[idx]; i++) begin
            v[1 + i] = b[i];
            ones += int'(b[i]);
        end
        pos = 1 + DB_A[idx];
        if (PAR_A[idx] != 0) begin
            v[pos] = (PAR_A[idx] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            pos++;
        end
        for (int s = 0; s < STOP_A[idx]; s++) v[pos + s] = 1'b1;
        return v;
    endfunction

    // Watches one line; decodes every frame and scores it against the model queue.
    task automatic mon(input int idx);
        int cpb;
        int len;
        int start;
        int bad;
        bit abort;
        logic [31:0] obs;
        logic [31:0] expv;
        logic s_arr [64];
        logic [8:0] b;
        cpb = CPB_A[idx];
        len = periods(idx) * cpb;
        forever begin
            @(negedge clk);
            if (rst_w[idx] && tx_w[idx] == 1'b0) begin
                start = cyc;
                abort = 1'b0;
                obs = '0;
                for (int k = 0; k < len; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_w[idx]) begin
                        abort = 1'b1;
                        break;
                    end
                    s_arr[k] = tx_w[idx];
                    if ((k % cpb) == (cpb / 2)) obs[k / cpb] = tx_w[idx];
                end
                if (!abort) begin
                    bad = 0;
                    for (int k = 0; k < len; k++)
                        if (s_arr[k] !== obs[k / cpb]) bad++;
                    start_log[idx][frames[idx] % 64] = start;
                    frames[idx]++;
                    if (exp_rd[idx] == exp_wr[idx]) begin
                        check("spurious_frame", 32'(exp_wr[idx] - exp_rd[idx]), 32'd1);
                    end else begin
                        b = exp_mem[idx][exp_rd[idx] % 64];
                        exp_rd[idx]++;
                        expv = frame_vec(idx, b);
                        $display("[TB] inst %0d frame start=%0d word=%03h bits=%0h", idx, start, b, obs);
                        check("frame_bits", obs, expv);
                        check("bit_hold", 32'(bad), 32'd0);
                    end
                    if (exp_start[idx] >= 0) begin
                        check("start_latency", 32'(start), 32'(exp_start[idx]));
                        exp_start[idx] = -1;
                    end
                end
            end
        end
    endtask

    task automatic drive_wr(input int idx, input logic [8:0] val, input bit acc);
        @(negedge clk);
        data_w[idx] = val;
        new_data_w[idx] = 1'b1;
        if (acc) begin
            exp_mem[idx][exp_wr[idx] % 64] = val;
            exp_wr[idx]++;
        end
        $display("[TB] inst %0d write %03h accept=%0d", idx, val, acc);
    endtask

    task automatic idle_wr(input int idx);
        @(negedge clk);
        new_data_w[idx] = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[idx] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[idx]) check("idle_timeout", 32'(busy_w[idx]), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int f0;
        int r;
        int n;
        int l0;
        logic [8:0] v;

        for (int i = 0; i < NI; i++) begin
            rst_w[i] = 1'b0;
            block_w[i] = 1'b0;
            new_data_w[i] = 1'b0;
            data_w[i] = '0;
            exp_wr[i] = 0;
            exp_rd[i] = 0;
            exp_start[i] = -1;
            frames[i] = 0;
        end
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_tx", 32'(tx_w[i]), 32'd1);
            check("rst_busy", 32'(busy_w[i]), 32'd0);
            check("rst_full", 32'(full_w[i]), 32'd0);
            check("rst_ovf", 32'(ovf_w[i]), 32'd0);
            check("rst_count", 32'(cnt_w[i]), 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst_w[i] = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 single word: latency, frame content, busy falling with the line
        l0 = periods(0) * CPB_A[0];
        drive_wr(0, 9'h0A5, 1'b1);
        s0 = cyc + 3;
        exp_start[0] = s0;
        idle_wr(0);
        wait_cyc(s0 + l0 - 1);
        check("busy_last_stop", 32'(busy_w[0]), 32'd1);
        @(negedge clk);
        check("busy_after_frame", 32'(busy_w[0]), 32'd0);
        wait_idle(0);
        check("frames_a5", 32'(frames[0]), 32'd1);

        // Parity formats, two words each to measure exact frame length
        for (int i = 1; i <= 2; i++) begin
            f0 = frames[i];
            drive_wr(i, 9'h0A5, 1'b1);
            drive_wr(i, 9'h05A, 1'b1);
            idle_wr(i);
            wait_idle(i);
            check("par_frames", 32'(frames[i] - f0), 32'd2);
            check("par_len", 32'(start_log[i][(f0 + 1) % 64] - start_log[i][f0 % 64]),
                  32'(periods(i) * CPB_A[i]));
        end

        // Burst of six from idle: five accepted, sixth overflows
        f0 = frames[0];
        for (int k = 0; k < 6; k++) begin
            v = 9'($urandom_range(0, 255));
            drive_wr(0, v, k < 5);
            if (k == 0) exp_start[0] = cyc + 3;
            if (k == 4) check("full_before_5th", 32'(full_w[0]), 32'd0);
            if (k == 5) check("full_before_6th", 32'(full_w[0]), 32'd1);
        end
        idle_wr(0);
        check("overflow_pulse", 32'(ovf_w[0]), 32'd1);
        check("count_full", 32'(cnt_w[0]), 32'd4);
        @(negedge clk);
        check("overflow_clear", 32'(ovf_w[0]), 32'd0);
        wait_idle(0);
        check("burst_frames", 32'(frames[0] - f0), 32'd5);
        check("burst_span", 32'(start_log[0][(f0 + 4) % 64] - start_log[0][f0 % 64]), 32'(4 * l0));

        // Block holds a queued word; release latency; block mid-frame
        @(negedge clk);
        block_w[0] = 1'b1;
        repeat (2) @(negedge clk);
        f0 = frames[0];
        drive_wr(0, 9'h03C, 1'b1);
        idle_wr(0);
        repeat (6) @(negedge clk);
        check("blk_tx", 32'(tx_w[0]), 32'd1);
        check("blk_busy", 32'(busy_w[0]), 32'd1);
        check("blk_count", 32'(cnt_w[0]), 32'd1);
        @(negedge clk);
        block_w[0] = 1'b0;
        s0 = cyc + 3;
        exp_start[0] = s0;
        drive_wr(0, 9'h081, 1'b1);
        idle_wr(0);
        wait_cyc(s0 + 10);
        block_w[0] = 1'b1;
        wait_cyc(s0 + l0 + 8);
        check("blk_mid_frames", 32'(frames[0] - f0), 32'd1);
        check("blk_mid_tx", 32'(tx_w[0]), 32'd1);
        check("blk_mid_count", 32'(cnt_w[0]), 32'd1);
        @(negedge clk);
        block_w[0] = 1'b0;
        exp_start[0] = cyc + 3;
        wait_idle(0);
        check("blk_frames", 32'(frames[0] - f0), 32'd2);

        // Asynchronous reset mid-DATA with two words queued
        drive_wr(0, 9'h0F0, 1'b1);
        s0 = cyc + 3;
        drive_wr(0, 9'h011, 1'b1);
        drive_wr(0, 9'h022, 1'b1);
        idle_wr(0);
        wait_cyc(s0 + 3 * CPB_A[0] + 1);
        #2 rst_w[0] = 1'b0;
        #1;
        check("arst_tx", 32'(tx_w[0]), 32'd1);
        check("arst_count", 32'(cnt_w[0]), 32'd0);
        check("arst_busy", 32'(busy_w[0]), 32'd0);
        repeat (2) @(negedge clk);
        exp_rd[0] = exp_wr[0];
        exp_start[0] = -1;
        f0 = frames[0];
        rst_w[0] = 1'b1;
        repeat (3 * l0) @(negedge clk);
        check("arst_no_frame", 32'(frames[0] - f0), 32'd0);
        check("arst_idle_tx", 32'(tx_w[0]), 32'd1);

        // Five-bit payload with upper bits set on the bench side
        f0 = frames[3];
        drive_wr(3, 9'h1FF, 1'b1);
        drive_wr(3, 9'h1E0, 1'b1);
        idle_wr(3);
        wait_idle(3);
        check("db5_frames", 32'(frames[3] - f0), 32'd2);
        check("db5_len", 32'(start_log[3][(f0 + 1) % 64] - start_log[3][f0 % 64]), 32'(7 * CPB_A[3]));

        // Randomised bursts from idle on every format
        for (int i = 0; i < NI; i++) begin
            for (r = 0; r < 3; r++) begin
                wait_idle(i);
                f0 = frames[i];
                n = $urandom_range(1, DEPTH + 1);
                for (int k = 0; k < n; k++) begin
                    v = 9'($urandom_range(0, 511));
                    drive_wr(i, v, 1'b1);
                    if (k == 0) exp_start[i] = cyc + 3;
                end
                idle_wr(i);
                wait_idle(i);
                check("rand_drain", 32'(exp_rd[i]), 32'(exp_wr[i]));
                check("rand_span", 32'(start_log[i][(f0 + n - 1) % 64] - start_log[i][f0 % 64]),
                      32'((n - 1) * periods(i) * CPB_A[i]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
